// File: rtl/seq_shift_rotate_unit.sv
// seq_shift_rotate_unit
//   Multi-cycle shift/rotate engine. An operation is accepted in IDLE on
//   start, then the word moves one bit position per clock until the latched
//   amount is used up. The result is published on op1 together with a
//   one-cycle done pulse. op1 holds until the next operation completes.
//
//   Modes: 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101-111 reserved
//   (a reserved mode passes a through unchanged).
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (aborts any operation in flight)
//   start : request, sampled only in IDLE
//   mode  : operation select, sampled with start
//   a     : operand, sampled with start
//   amt   : shift amount 0..WIDTH-1, sampled with start
//   op1   : registered result
//   busy  : high while an operation is in flight (state != IDLE)
//   done  : one-cycle completion pulse
//   co    : last bit shifted/rotated out (only with SHIFT_CARRY_OUT_EN)
//
// Optional feature macro: SHIFT_CARRY_OUT_EN adds the co output.
module seq_shift_rotate_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] amt,
`ifdef SHIFT_CARRY_OUT_EN
  output logic               co,
`endif
  output logic [WIDTH-1:0]   op1,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] M_LSL = 3'd0;
  localparam logic [2:0] M_LSR = 3'd1;
  localparam logic [2:0] M_ASR = 3'd2;
  localparam logic [2:0] M_ROL = 3'd3;
  localparam logic [2:0] M_ROR = 3'd4;

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic [2:0]         mode_q;

  // One single-bit step of the latched operation.
  function automatic logic [WIDTH-1:0] step(input logic [2:0] m,
                                            input logic [WIDTH-1:0] v);
    case (m)
      M_LSL:   return {v[WIDTH-2:0], 1'b0};
      M_LSR:   return {1'b0, v[WIDTH-1:1]};
      M_ASR:   return {v[WIDTH-1], v[WIDTH-1:1]};
      M_ROL:   return {v[WIDTH-2:0], v[WIDTH-1]};
      M_ROR:   return {v[0], v[WIDTH-1:1]};
      default: return v;
    endcase
  endfunction

`ifdef SHIFT_CARRY_OUT_EN
  // Bit leaving the word on the current step; tracked every step so the
  // value left after the final step is the carry for the whole operation.
  logic carry;
  logic carry_next;
  always_comb begin
    carry_next = ((mode_q == M_LSL) || (mode_q == M_ROL)) ? work[WIDTH-1] : work[0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      mode_q <= 3'b000;
      op1    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SHIFT_CARRY_OUT_EN
      carry  <= 1'b0;
      co     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work   <= a;
            mode_q <= mode;
            // Reserved modes load a zero count so the operand passes through.
            cnt    <= (mode > M_ROR) ? '0 : amt;
`ifdef SHIFT_CARRY_OUT_EN
            carry  <= 1'b0;
`endif
            state  <= SHIFT;
            busy   <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            work <= step(mode_q, work);
            cnt  <= cnt - 1'b1;
`ifdef SHIFT_CARRY_OUT_EN
            carry <= carry_next;
`endif
          end else begin
            op1   <= work;
            done  <= 1'b1;
`ifdef SHIFT_CARRY_OUT_EN
            co    <= carry;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_rotate_unit.sv
module tb_seq_shift_rotate_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] mode;
  logic [7:0] a;
  logic [2:0] amt;
  logic [7:0] op1;
  logic       busy;
  logic       done;
`ifdef SHIFT_CARRY_OUT_EN
  logic       co;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_shift_rotate_unit #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .a     (a),
    .amt   (amt),
`ifdef SHIFT_CARRY_OUT_EN
    .co    (co),
`endif
    .op1   (op1),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to completion. exp_lat counts negedges
  // after the accepting edge up to the one where done is first seen.
  task automatic run(input string tag, input logic [2:0] m, input logic [7:0] av,
                     input logic [2:0] am, input logic [7:0] exp_op1,
                     input logic exp_co, input int exp_lat);
    logic [7:0] prev;
    int lat;
    prev = op1;
    @(negedge clk);
    start = 1'b1; mode = m; a = av; amt = am;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk({tag, "_busy_early"}, busy, 1);
        chk({tag, "_op1_hold"}, op1, prev);
      end
    end while (!done && lat < 40);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_op1"}, op1, exp_op1);
    chk({tag, "_busy_at_done"}, busy, 1);
`ifdef SHIFT_CARRY_OUT_EN
    chk({tag, "_co"}, co, exp_co);
`else
    if (exp_co === 1'bx) $display("note: unexpected carry x");
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_op1_kept"}, op1, exp_op1);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; mode = 3'd0; a = 8'h00; amt = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_op1", op1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef SHIFT_CARRY_OUT_EN
    chk("rst_co", co, 0);
`endif
    rst = 1'b0;

    run("lsl3",  3'b000, 8'b1001_0110, 3'd3, 8'b1011_0000, 1'b0, 5);
    chk("lsl3_idle", busy, 0);
    run("asr2",  3'b010, 8'b1001_0110, 3'd2, 8'b1110_0101, 1'b1, 4);
    run("rol1",  3'b011, 8'b1001_0110, 3'd1, 8'b0010_1101, 1'b1, 3);
    run("ror7",  3'b100, 8'b1001_0110, 3'd7, 8'b0010_1101, 1'b0, 9);
    run("rsvd",  3'b111, 8'hA5,        3'd5, 8'hA5,        1'b0, 2);
    run("lsr0",  3'b001, 8'h3C,        3'd0, 8'h3C,        1'b0, 2);

    // LSR 0xFF by 7 with start pulsed and operands scrambled while busy.
    @(negedge clk);
    start = 1'b1; mode = 3'b001; a = 8'hFF; amt = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) ndone++;
      start = (i < 8) && (i % 2 == 0);
      a = 8'h00; mode = 3'b000; amt = 3'd1;
    end
    start = 1'b0;
    chk("ign_ndone", ndone, 1);
    chk("ign_op1", op1, 8'h01);
    chk("ign_idle", busy, 0);
`ifdef SHIFT_CARRY_OUT_EN
    chk("ign_co", co, 1);
`endif

    // Abort LSL 0xFF by 6 during its third SHIFT cycle.
    @(negedge clk);
    start = 1'b1; mode = 3'b000; a = 8'hFF; amt = 3'd6;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_op1", op1, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    run("lsl4",  3'b000, 8'h01, 3'd4, 8'h10, 1'b0, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
